// File: rtl/crc_arb_pkg.sv
// crc_arb_pkg: shared defaults, issue-stage state type and tag ID type for
// the CRC request arbiter.
package crc_arb_pkg;

    localparam int unsigned DEF_NUM_REQ       = 4;
    localparam int unsigned DEF_CRC_REQ_WIDTH = 36;
    localparam int unsigned DEF_CRC_RSP_WIDTH = 149;
    localparam int unsigned DEF_TAG_DEPTH     = 8;

    // One-entry issue register: holds nothing, or one granted request.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] tag_id_t;

endpackage

// File: rtl/crc_tag_fifo.sv
// crc_tag_fifo: synchronous FIFO of outstanding requester IDs with a
// registered occupancy count and full/empty flags. DEPTH is a power of two,
// so pointers wrap naturally.
module crc_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a push is accepted even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and count values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/crc_req_arb.sv
// crc_req_arb: round-robin arbiter sharing one CRC engine among NUM_REQ
// requesters. A one-entry issue register feeds the engine; granted IDs are
// queued in crc_tag_fifo so in-order engine responses route back to the
// originating requester. Define CRC_ARB_ERR_IRQ_EN to raise a sticky o_int on
// responses that arrive with no request outstanding.
module crc_req_arb
    import crc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned CRC_REQ_WIDTH = DEF_CRC_REQ_WIDTH,
    parameter int unsigned CRC_RSP_WIDTH = DEF_CRC_RSP_WIDTH,
    parameter int unsigned TAG_DEPTH     = DEF_TAG_DEPTH
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [NUM_REQ*CRC_REQ_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]                o_req_ready,
    output logic                              o_crc_req_valid,
    output logic [CRC_REQ_WIDTH-1:0]          o_crc_req_data,
    input  logic                              i_crc_req_ready,
    input  logic                              i_crc_done_valid,
    input  logic [CRC_RSP_WIDTH-1:0]          i_crc_done_data,
    output logic                              o_crc_done_ready,
    output logic [NUM_REQ-1:0]                o_rsp_valid,
    output logic [CRC_RSP_WIDTH-1:0]          o_rsp_data,
    input  logic [NUM_REQ-1:0]                i_rsp_ready,
    input  logic                              i_int_clr,
    output logic                              o_int
);

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

    issue_state_e             state_q, state_d;
    logic [CRC_REQ_WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [ID_W-1:0]          last_grant_q, last_grant_d;

    logic [ID_W-1:0]          pick;
    logic [ID_W-1:0]          rr_idx;
    logic                     any_valid;
    logic [CNT_W-1:0]         outstanding;
    logic                     credit_ok;
    logic                     crc_hs;
    logic                     req_hs;
    logic                     orphan;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic [ID_W-1:0]          fifo_head;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full_unused;
    logic                     fifo_empty;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        pick      = last_grant_q;
        rr_idx    = '0;
        any_valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
            if (!any_valid && i_req_valid[rr_idx]) begin
                any_valid = 1'b1;
                pick      = rr_idx;
            end
        end
    end

    // The request held in the issue register counts against tag capacity.
    assign outstanding = fifo_count + {{(CNT_W-1){1'b0}}, (state_q == ST_FULL)};
    assign credit_ok   = (outstanding < CNT_W'(TAG_DEPTH));
    assign crc_hs      = (state_q == ST_FULL) && i_crc_req_ready;
    assign req_hs      = !i_reset && any_valid && credit_ok &&
                         ((state_q == ST_EMPTY) || crc_hs);

    // Issue-stage next state: drain on engine handshake, reload on grant.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        o_req_ready  = '0;
        if (crc_hs) begin
            state_d = ST_EMPTY;
        end
        if (req_hs) begin
            o_req_ready[pick] = 1'b1;
            state_d           = ST_FULL;
            data_d            = i_req_data[32'(pick)*CRC_REQ_WIDTH +: CRC_REQ_WIDTH];
            grant_d           = pick;
            last_grant_d      = pick;
        end
    end

    // Issue-stage control registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_EMPTY;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Payload register; only observed while FULL.
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign o_crc_req_valid = (state_q == ST_FULL);
    assign o_crc_req_data  = data_q;

    assign fifo_push = crc_hs;
    assign fifo_pop  = !fifo_empty && i_crc_done_valid && i_rsp_ready[fifo_head];

    crc_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (fifo_push),
        .push_data (grant_q),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full_unused),
        .empty     (fifo_empty)
    );

    // Route engine responses to the oldest outstanding requester; drop orphans.
    always_comb begin
        o_rsp_valid      = '0;
        o_crc_done_ready = 1'b1;
        if (!fifo_empty) begin
            o_rsp_valid[fifo_head] = i_crc_done_valid && !i_reset;
            o_crc_done_ready       = i_rsp_ready[fifo_head];
        end
    end

    assign o_rsp_data = i_crc_done_data;
    assign orphan     = fifo_empty && i_crc_done_valid;

`ifdef CRC_ARB_ERR_IRQ_EN
    logic int_q, int_d;

    // Sticky orphan flag; a new orphan beats a simultaneous clear.
    always_comb begin
        int_d = int_q;
        if (orphan) begin
            int_d = 1'b1;
        end else if (i_int_clr) begin
            int_d = 1'b0;
        end
    end

    // Interrupt register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            int_q <= 1'b0;
        end else begin
            int_q <= int_d;
        end
    end

    assign o_int = int_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = i_int_clr ^ orphan;
    assign o_int             = 1'b0;
`endif

endmodule

// File: tb/tb_crc_req_arb.sv
// tb_crc_req_arb: directed bench for crc_req_arb. A queue-based model of the
// arbiter predicts every output each cycle; directed scenarios add literal
// expectations for grants, routing, tag capacity, orphans and reset.
module tb_crc_req_arb;

    localparam int N  = 4;
    localparam int RW = 36;
    localparam int SW = 149;
    localparam int TD = 8;
`ifdef CRC_ARB_ERR_IRQ_EN
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic EXP_IRQ = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [N-1:0]    i_req_valid = '0;
    logic [N*RW-1:0] i_req_data = '0;
    logic [N-1:0]    o_req_ready;
    logic            o_crc_req_valid;
    logic [RW-1:0]   o_crc_req_data;
    logic            i_crc_req_ready = 1'b0;
    logic            i_crc_done_valid = 1'b0;
    logic [SW-1:0]   i_crc_done_data = '0;
    logic            o_crc_done_ready;
    logic [N-1:0]    o_rsp_valid;
    logic [SW-1:0]   o_rsp_data;
    logic [N-1:0]    i_rsp_ready = '0;
    logic            i_int_clr = 1'b0;
    logic            o_int;

    always #5 clk = ~clk;

    crc_req_arb #(
        .NUM_REQ       (N),
        .CRC_REQ_WIDTH (RW),
        .CRC_RSP_WIDTH (SW),
        .TAG_DEPTH     (TD)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_req_valid      (i_req_valid),
        .i_req_data       (i_req_data),
        .o_req_ready      (o_req_ready),
        .o_crc_req_valid  (o_crc_req_valid),
        .o_crc_req_data   (o_crc_req_data),
        .i_crc_req_ready  (i_crc_req_ready),
        .i_crc_done_valid (i_crc_done_valid),
        .i_crc_done_data  (i_crc_done_data),
        .o_crc_done_ready (o_crc_done_ready),
        .o_rsp_valid      (o_rsp_valid),
        .o_rsp_data       (o_rsp_data),
        .i_rsp_ready      (i_rsp_ready),
        .i_int_clr        (i_int_clr),
        .o_int            (o_int)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Model state: a pending request slot plus the queue of outstanding IDs.
    bit            m_slot_full = 1'b0;
    logic [RW-1:0] m_slot_data = '0;
    int            m_slot_id   = 0;
    int            m_tags[$];
    int            m_last      = N - 1;
    bit            m_irq       = 1'b0;
    bit            model_en    = 1'b0;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Outputs implied by the model state and the current inputs.
    function automatic void model_outs(output logic [N-1:0] rr, output logic [N-1:0] rv,
                                       output logic dr);
        int  outst;
        bit  found;
        outst = m_tags.size() + (m_slot_full ? 1 : 0);
        found = 1'b0;
        rr = '0;
        rv = '0;
        dr = 1'b1;
        if (!i_reset && (!m_slot_full || i_crc_req_ready) && outst < TD) begin
            for (int k = 1; k <= N; k++) begin
                int r = (m_last + k) % N;
                if (!found && i_req_valid[r]) begin
                    rr[r] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        if (m_tags.size() > 0) begin
            if (!i_reset) rv[m_tags[0]] = i_crc_done_valid;
            dr = i_rsp_ready[m_tags[0]];
        end
    endfunction

    task automatic model_step();
        logic [N-1:0] rr, rv;
        logic         dr;
        bit           orphan;
        if (i_reset) begin
            m_slot_full = 1'b0;
            m_tags.delete();
            m_last = N - 1;
            m_irq  = 1'b0;
        end else begin
            model_outs(rr, rv, dr);
            orphan = (m_tags.size() == 0) && i_crc_done_valid;
            if (m_tags.size() > 0 && i_crc_done_valid && dr) void'(m_tags.pop_front());
            if (m_slot_full && i_crc_req_ready) begin
                m_tags.push_back(m_slot_id);
                m_slot_full = 1'b0;
            end
            if (rr != '0) begin
                for (int j = 0; j < N; j++) if (rr[j]) m_slot_id = j;
                m_slot_full = 1'b1;
                m_slot_data = i_req_data[m_slot_id*RW +: RW];
                m_last      = m_slot_id;
            end
`ifdef CRC_ARB_ERR_IRQ_EN
            if (orphan) m_irq = 1'b1;
            else if (i_int_clr) m_irq = 1'b0;
`else
            if (orphan) m_irq = 1'b0;
`endif
        end
    endtask

    task automatic compare();
        logic [N-1:0] rr, rv;
        logic         dr;
        model_outs(rr, rv, dr);
        chk("req_ready", 160'(o_req_ready), 160'(rr));
        chk("crc_req_valid", 160'(o_crc_req_valid), 160'(m_slot_full));
        if (m_slot_full) chk("crc_req_data", 160'(o_crc_req_data), 160'(m_slot_data));
        chk("rsp_valid", 160'(o_rsp_valid), 160'(rv));
        if (rv != '0) chk("rsp_data", 160'(o_rsp_data), 160'(i_crc_done_data));
        chk("done_ready", 160'(o_crc_done_ready), 160'(dr));
        chk("int", 160'(o_int), 160'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid      = '0;
        i_crc_req_ready  = 1'b0;
        i_crc_done_valid = 1'b0;
        i_rsp_ready      = '0;
        i_int_clr        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    logic [N-1:0] seq [5];
    logic [SW-1:0] rsp_a;
    int grants;

    initial begin
        fork
            forever begin
                @(posedge clk);
                model_step();
                model_en = 1'b1;
            end
            forever begin
                @(negedge clk);
                if (model_en) compare();
            end
        join_none

        for (int k = 0; k < N; k++) i_req_data[k*RW +: RW] = RW'(36'hA_0000_0000 + 36'(k) * 36'h1_0101_0101);
        rsp_a = {21'h1_5A5A, 64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF};

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_crc_valid", 160'(o_crc_req_valid), 160'(0));
        chk("rst_req_ready", 160'(o_req_ready), 160'(0));
        chk("rst_rsp_valid", 160'(o_rsp_valid), 160'(0));
        chk("rst_int", 160'(o_int), 160'(0));
        do_reset();

        // Single requester 2: N+1 latency and routing back to requester 2
        i_req_data[2*RW +: RW] = 36'h1_2345_6789;
        i_req_valid     = 4'b0100;
        i_crc_req_ready = 1'b1;
        i_rsp_ready     = 4'b1111;
        @(negedge clk);
        chk("r2_grant", 160'(o_req_ready), 160'(4'b0100));
        tick();
        i_req_valid = '0;
        @(negedge clk);
        chk("r2_issue_valid", 160'(o_crc_req_valid), 160'(1));
        chk("r2_issue_data", 160'(o_crc_req_data), 160'(36'h1_2345_6789));
        tick();
        i_crc_done_valid = 1'b1;
        i_crc_done_data  = rsp_a;
        @(negedge clk);
        chk("r2_rsp_valid", 160'(o_rsp_valid), 160'(4'b0100));
        chk("r2_rsp_data", 160'(o_rsp_data), 160'(rsp_a));
        tick();
        i_crc_done_valid = 1'b0;
        @(negedge clk);
        chk("r2_drained_crc_valid", 160'(o_crc_req_valid), 160'(0));

        // All requesters streaming: 0,1,2,3,0 then reset with 4 tags outstanding
        do_reset();
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        i_req_valid     = 4'b1111;
        i_crc_req_ready = 1'b1;
        i_rsp_ready     = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", i), 160'(o_req_ready), 160'(seq[i]));
            tick();
        end
        @(negedge clk);
        chk("rr_full_before_reset", 160'(o_crc_req_valid), 160'(1));
        i_reset = 1'b1;
        tick();
        i_reset     = 1'b0;
        i_rsp_ready = '0;
        @(negedge clk);
        chk("rst_mid_crc_valid", 160'(o_crc_req_valid), 160'(0));
        chk("rst_mid_rsp_valid", 160'(o_rsp_valid), 160'(0));
        chk("rst_mid_empty", 160'(o_crc_done_ready), 160'(1));
        chk("rst_mid_next_grant", 160'(o_req_ready), 160'(4'b0001));

        // Tag capacity: requester 1 streaming stalls once 8 are outstanding
        do_reset();
        i_req_valid     = 4'b0010;
        i_crc_req_ready = 1'b1;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_req_ready == 4'b0010) grants++;
            tick();
        end
        chk("cap_grant_count", 160'(grants), 160'(TD));
        i_crc_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cap_stalled", 160'(o_req_ready), 160'(0));
            tick();
        end
        i_crc_done_valid = 1'b1;
        i_crc_done_data  = rsp_a;
        i_rsp_ready      = 4'b1111;
        @(negedge clk);
        chk("cap_rsp_to_1", 160'(o_rsp_valid), 160'(4'b0010));
        tick();
        i_crc_done_valid = 1'b0;
        @(negedge clk);
        chk("cap_reopen", 160'(o_req_ready), 160'(4'b0010));

        // Issue 3 then 0; requester 3 back-pressures its response for 5 cycles
        do_reset();
        i_crc_req_ready = 1'b1;
        i_req_valid     = 4'b1000;
        @(negedge clk);
        chk("ord_grant3", 160'(o_req_ready), 160'(4'b1000));
        tick();
        i_req_valid = 4'b0001;
        @(negedge clk);
        chk("ord_grant0", 160'(o_req_ready), 160'(4'b0001));
        tick();
        i_req_valid = '0;
        tick();
        i_crc_done_valid = 1'b1;
        i_crc_done_data  = ~rsp_a;
        i_rsp_ready      = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ord_hold_ready", 160'(o_crc_done_ready), 160'(0));
            chk("ord_hold_valid", 160'(o_rsp_valid), 160'(4'b1000));
            tick();
        end
        i_rsp_ready = 4'b1111;
        @(negedge clk);
        chk("ord_first_to3", 160'(o_rsp_valid), 160'(4'b1000));
        chk("ord_first_ready", 160'(o_crc_done_ready), 160'(1));
        tick();
        @(negedge clk);
        chk("ord_second_to0", 160'(o_rsp_valid), 160'(4'b0001));
        tick();
        i_crc_done_valid = 1'b0;

        // Orphan response and interrupt behaviour
        do_reset();
        i_crc_done_valid = 1'b1;
        @(negedge clk);
        chk("orph_rsp_valid", 160'(o_rsp_valid), 160'(0));
        chk("orph_done_ready", 160'(o_crc_done_ready), 160'(1));
        tick();
        i_crc_done_valid = 1'b0;
        @(negedge clk);
        chk("orph_int_set", 160'(o_int), 160'(EXP_IRQ));
        tick();
        @(negedge clk);
        chk("orph_int_sticky", 160'(o_int), 160'(EXP_IRQ));
        i_int_clr = 1'b1;
        tick();
        i_int_clr = 1'b0;
        @(negedge clk);
        chk("orph_int_clr", 160'(o_int), 160'(0));
        i_crc_done_valid = 1'b1;
        i_int_clr        = 1'b1;
        tick();
        i_crc_done_valid = 1'b0;
        i_int_clr        = 1'b0;
        @(negedge clk);
        chk("orph_set_wins", 160'(o_int), 160'(EXP_IRQ));
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
